// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard sequencer: FSM encodings and
// the control-output bundles driven in each pipeline situation.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } hz_state_t;

    typedef struct packed {
        logic cu_nop;
        logic pc_le;
        logic ifid_le;
        logic ifid_flush;
        logic pipe_freeze;
    } pipe_ctrl_t;

    // Normal flow; also the value presented while reset is asserted.
    localparam pipe_ctrl_t CTRL_RUN = '{cu_nop: 1'b0, pc_le: 1'b1, ifid_le: 1'b1,
                                        ifid_flush: 1'b0, pipe_freeze: 1'b0};
    // Bubble: NOP into ID/EX while PC and IF/ID hold the dependent instruction.
    localparam pipe_ctrl_t CTRL_BUBBLE = '{cu_nop: 1'b1, pc_le: 1'b0, ifid_le: 1'b0,
                                           ifid_flush: 1'b0, pipe_freeze: 1'b0};
    localparam pipe_ctrl_t CTRL_FLUSH = '{cu_nop: 1'b1, pc_le: 1'b1, ifid_le: 1'b1,
                                          ifid_flush: 1'b1, pipe_freeze: 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE = '{cu_nop: 1'b0, pc_le: 1'b0, ifid_le: 1'b0,
                                           ifid_flush: 1'b0, pipe_freeze: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load currently in EX will write. R0 is hard-wired and never hazards.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load,
    input  logic             ex_rf_le,
    output logic             hz
);

    logic w_rd_live;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rd_live = ex_load & ex_rf_le & (ex_rd != '0);
    assign w_rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
    assign w_rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);
    assign hz        = w_rd_live & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage pipeline sequencer: bubbles on load-use, flushes IF/ID on taken
// branches, freezes the pipe on RAM waits, and counts stall/flush activity.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int LOAD_BUBBLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load,
    input  logic             ex_rf_le,
    input  logic             br_taken,
    input  logic             ram_busy,
    input  logic             perf_clr,
    output logic             cu_nop,
    output logic             pc_le,
    output logic             ifid_le,
    output logic             ifid_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] LB_RELOAD = 2'(LOAD_BUBBLES - 1);
    localparam logic [1:0] FC_RELOAD = 2'(FLUSH_CYCLES - 1);

    hz_state_t        r_state;
    hz_state_t        r_ret_state;
    logic [1:0]       r_bcnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    hz_state_t  w_state_nxt;
    hz_state_t  w_ret_nxt;
    hz_state_t  w_eval_state;
    logic [1:0] w_bcnt_nxt;
    logic       w_flush_evt;
    logic       w_stall_evt;
    logic       w_hz;
    pipe_ctrl_t w_ctrl;
    pipe_ctrl_t w_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard_detect (
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2),
        .ex_rd     (ex_rd),
        .ex_load   (ex_load),
        .ex_rf_le  (ex_rf_le),
        .hz        (w_hz)
    );

    // Leaving MEM_WAIT behaves exactly like the interrupted state would have.
    assign w_eval_state = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret_state;
        w_bcnt_nxt  = r_bcnt;
        w_flush_evt = 1'b0;
        w_ctrl      = CTRL_RUN;
        if (ram_busy) begin
            w_ctrl      = CTRL_FREEZE;
            w_state_nxt = ST_MEM_WAIT;
            if (r_state != ST_MEM_WAIT) begin
                w_ret_nxt = r_state;
            end
        end else if (br_taken) begin
            // The squashed ID instruction makes any load-use match irrelevant.
            w_ctrl      = CTRL_FLUSH;
            w_flush_evt = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = ST_FLUSH;
                w_bcnt_nxt  = FC_RELOAD;
            end else begin
                w_state_nxt = ST_RUN;
                w_bcnt_nxt  = 2'd0;
            end
        end else begin
            case (w_eval_state)
                ST_LOAD_STALL: begin
                    w_ctrl      = CTRL_BUBBLE;
                    w_bcnt_nxt  = (r_bcnt != 2'd0) ? r_bcnt - 2'd1 : 2'd0;
                    w_state_nxt = (r_bcnt <= 2'd1) ? ST_RUN : ST_LOAD_STALL;
                end
                ST_FLUSH: begin
                    w_ctrl      = CTRL_FLUSH;
                    w_bcnt_nxt  = (r_bcnt != 2'd0) ? r_bcnt - 2'd1 : 2'd0;
                    w_state_nxt = (r_bcnt <= 2'd1) ? ST_RUN : ST_FLUSH;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    if (w_hz) begin
                        w_ctrl = CTRL_BUBBLE;
                        if (LOAD_BUBBLES > 1) begin
                            w_state_nxt = ST_LOAD_STALL;
                            w_bcnt_nxt  = LB_RELOAD;
                        end
                    end
                end
            endcase
        end
    end

    // Outputs fall back to the idle bundle the instant reset is asserted.
    assign w_out       = rst_n ? w_ctrl : CTRL_RUN;
    assign cu_nop      = w_out.cu_nop;
    assign pc_le       = w_out.pc_le;
    assign ifid_le     = w_out.ifid_le;
    assign ifid_flush  = w_out.ifid_flush;
    assign pipe_freeze = w_out.pipe_freeze;
    assign w_stall_evt = w_out.cu_nop | w_out.pipe_freeze;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_bcnt      <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_bcnt      <= w_bcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_flush_evt) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
